// File: rtl/jtkicker_mixer.sv
// jtkicker_mixer: N-layer priority/transparency resolver followed by a
// CPU/PROM-loadable RGB palette and a blanked RGB output register.
// Three pixel-enabled stages: priority -> palette read -> output.
module jtkicker_mixer #(
  parameter int LAYERS = 3,
  parameter int PXLW   = 8,
  parameter int COLW   = 4,
  parameter int PALAW  = 2 + PXLW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pxl_cen,
  input  logic [LAYERS*PXLW-1:0]   lyr_pxl,
  input  logic [LAYERS-1:0]        layer_en,
  input  logic                     prio_swap,
  input  logic                     LHBL,
  input  logic                     LVBL,
  input  logic [PALAW-1:0]         prog_addr,
  input  logic [3:0]               prog_data,
  input  logic [2:0]               prog_en,
  output logic [COLW-1:0]          red,
  output logic [COLW-1:0]          green,
  output logic [COLW-1:0]          blue,
  output logic                     LHBL_dly,
  output logic                     LVBL_dly
);

  localparam int PALSZ = 1 << PALAW;

  // Top COLW bits of a 4-bit palette nibble drive one output channel.
  function automatic logic [COLW-1:0] chan_sel(input logic [3:0] nib);
    return nib[3 -: COLW];
  endfunction

  // Palette storage, one nibble array per channel so that each prog_en
  // strobe writes its own channel independently.
  logic [3:0] pal_r [PALSZ];
  logic [3:0] pal_g [PALSZ];
  logic [3:0] pal_b [PALSZ];

  // Layer pixels unpacked into a fixed four-slot view; unused slots are
  // never opaque so the priority scan can always walk four entries.
  logic [PXLW-1:0] pxl [4];
  logic [3:0]      opaque;
  logic [1:0]      order [4];
  logic [PXLW-1:0] fb_pxl;
  logic [PALAW-1:0] win_addr;

  // Stage registers
  logic [PALAW-1:0] pal_addr_p0;
  logic             lhbl_p0, lvbl_p0, vld_p0;
  logic [11:0]      pal_rd_p1;
  logic             lhbl_p1, lvbl_p1, vld_p1;

  // Unpack layers and flag the ones that are enabled with a non-zero colour.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pxl[i]    = '0;
      opaque[i] = 1'b0;
    end
    for (int i = 0; i < LAYERS; i++) begin
      pxl[i]    = lyr_pxl[i*PXLW +: PXLW];
      opaque[i] = layer_en[i] && (lyr_pxl[i*PXLW +: 4] != 4'd0);
    end
  end

  // Effective ranking: layers 0 and 1 trade places when prio_swap is set.
  always_comb begin
    order[0] = prio_swap ? 2'd1 : 2'd0;
    order[1] = prio_swap ? 2'd0 : 2'd1;
    order[2] = 2'd2;
    order[3] = 2'd3;
  end

  // Pick the first opaque layer in effective order; with nothing opaque the
  // lowest-priority layer supplies the address (its colour field forced to
  // zero when that layer is disabled). Scanning from the bottom lets the
  // highest ranked opaque layer overwrite the rest.
  always_comb begin
    fb_pxl   = layer_en[LAYERS-1] ? pxl[LAYERS-1] : '0;
    win_addr = {2'(LAYERS-1), fb_pxl};
    for (int k = 3; k >= 0; k--) begin
      if (opaque[order[k]]) win_addr = {order[k], pxl[order[k]]};
    end
  end

  // Palette writes commit on any clock, regardless of pixel enable or reset.
  always_ff @(posedge clk) begin
    if (prog_en[0]) pal_r[prog_addr] <= prog_data;
    if (prog_en[1]) pal_g[prog_addr] <= prog_data;
    if (prog_en[2]) pal_b[prog_addr] <= prog_data;
  end

  // ---- stage 1: priority resolve, blanking sampled alongside ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pal_addr_p0 <= '0;
      lhbl_p0     <= 1'b0;
      lvbl_p0     <= 1'b0;
      vld_p0      <= 1'b0;
    end else if (pxl_cen) begin
      pal_addr_p0 <= win_addr;
      lhbl_p0     <= LHBL;
      lvbl_p0     <= LVBL;
      vld_p0      <= 1'b1;
    end
  end

  // ---- stage 2: palette read (old data when written in the same clock) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pal_rd_p1 <= '0;
      lhbl_p1   <= 1'b0;
      lvbl_p1   <= 1'b0;
      vld_p1    <= 1'b0;
    end else if (pxl_cen) begin
      pal_rd_p1 <= {pal_b[pal_addr_p0], pal_g[pal_addr_p0], pal_r[pal_addr_p0]};
      lhbl_p1   <= lhbl_p0;
      lvbl_p1   <= lvbl_p0;
      vld_p1    <= vld_p0;
    end
  end

  // ---- stage 3: blanked RGB and delayed blanking ----
  always_ff @(posedge clk) begin
    if (rst) begin
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      LHBL_dly <= lhbl_p1;
      LVBL_dly <= lvbl_p1;
      if (vld_p1 && lhbl_p1 && lvbl_p1) begin
        red   <= chan_sel(pal_rd_p1[3:0]);
        green <= chan_sel(pal_rd_p1[7:4]);
        blue  <= chan_sel(pal_rd_p1[11:8]);
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jtkicker_mixer.sv
// Testbench for jtkicker_mixer: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_jtkicker_mixer;
  localparam int LAYERS = 3;
  localparam int PXLW   = 8;
  localparam int COLW   = 4;
  localparam int PALAW  = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pxl_cen = 1'b0;
  logic [23:0]      lyr_pxl = '0;
  logic [2:0]       layer_en = 3'b111;
  logic             prio_swap = 1'b0;
  logic             LHBL = 1'b1;
  logic             LVBL = 1'b1;
  logic [9:0]       prog_addr = '0;
  logic [3:0]       prog_data = '0;
  logic [2:0]       prog_en = '0;
  logic [3:0]       red, green, blue;
  logic             LHBL_dly, LVBL_dly;
  logic [13:0]      dut_out;

  int   tests = 0;
  int   fails = 0;
  int   shown = 0;
  logic checking = 1'b0;

  // write requested to ride along with the next pixel step
  logic [2:0] pend_en = '0;
  logic [9:0] pend_addr = '0;
  logic [3:0] pend_data = '0;

  jtkicker_mixer #(.LAYERS(LAYERS), .PXLW(PXLW), .COLW(COLW), .PALAW(PALAW)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .lyr_pxl(lyr_pxl),
    .layer_en(layer_en), .prio_swap(prio_swap), .LHBL(LHBL), .LVBL(LVBL),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_en(prog_en),
    .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  assign dut_out = {red, green, blue, LHBL_dly, LVBL_dly};

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0]  mr [1024];
  logic [3:0]  mg [1024];
  logic [3:0]  mb [1024];
  logic [9:0]  h_addr [4];
  logic        h_hb [4];
  logic        h_vb [4];
  logic [11:0] h_col [4];
  int          ncen = 0;
  logic [13:0] exp_out = '0;

  function automatic logic [9:0] ref_addr(input logic [23:0] px, input logic [2:0] en,
                                          input logic sw);
    int order [3];
    int l;
    logic [7:0] p;
    if (sw) order = '{1, 0, 2};
    else    order = '{0, 1, 2};
    for (int k = 0; k < 3; k++) begin
      l = order[k];
      p = px[l*8 +: 8];
      if (en[l[1:0]] && p[3:0] != 4'd0) return {l[1:0], p};
    end
    if (en[2]) return {2'd2, px[23:16]};
    return {2'd2, 8'h00};
  endfunction

  // Output for the pixel sampled on pxl_cen number n appears at pxl_cen n+2,
  // using the palette contents seen at pxl_cen n+1 (before that clock's writes).
  initial begin
    int i0, i1, i2;
    logic [11:0] col;
    forever begin
      @(posedge clk);
      if (rst) begin
        ncen    = 0;
        exp_out = '0;
      end else if (pxl_cen) begin
        i0 = ncen; i1 = ncen - 1; i2 = ncen - 2;
        h_addr[i0[1:0]] = ref_addr(lyr_pxl, layer_en, prio_swap);
        h_hb[i0[1:0]]   = LHBL;
        h_vb[i0[1:0]]   = LVBL;
        if (ncen >= 1)
          h_col[i1[1:0]] = {mb[h_addr[i1[1:0]]], mg[h_addr[i1[1:0]]], mr[h_addr[i1[1:0]]]};
        if (ncen >= 2) begin
          col = h_col[i2[1:0]];
          if (h_hb[i2[1:0]] && h_vb[i2[1:0]])
            exp_out = {col[3:0], col[7:4], col[11:8], 2'b11};
          else
            exp_out = {12'h000, h_hb[i2[1:0]], h_vb[i2[1:0]]};
        end
        ncen++;
      end
      if (prog_en[0]) mr[prog_addr] = prog_data;
      if (prog_en[1]) mg[prog_addr] = prog_data;
      if (prog_en[2]) mb[prog_addr] = prog_data;
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        tests++;
        if (dut_out !== exp_out) begin
          fails++;
          if (shown < 20) begin
            shown++;
            $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, dut_out, exp_out);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input logic [13:0] e);
    tests++;
    if (dut_out !== e) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", nm, dut_out, e);
    end
  endtask

  task automatic step(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                      input logic [2:0] en, input logic sw, input logic hb, input logic vb);
    @(negedge clk);
    lyr_pxl   = {l2, l1, l0};
    layer_en  = en;
    prio_swap = sw;
    LHBL      = hb;
    LVBL      = vb;
    pxl_cen   = 1'b1;
    prog_en   = pend_en;
    prog_addr = pend_addr;
    prog_data = pend_data;
    pend_en   = '0;
    @(negedge clk);
    pxl_cen = 1'b0;
    prog_en = '0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [2:0] en, input logic [3:0] d);
    @(negedge clk);
    prog_addr = a;
    prog_en   = en;
    prog_data = d;
  endtask

  task automatic wr_done();
    @(negedge clk);
    prog_en = '0;
  endtask

  localparam logic [13:0] RED   = {4'hF, 4'h0, 4'h0, 2'b11};
  localparam logic [13:0] GREEN = {4'h0, 4'hF, 4'h0, 2'b11};

  initial begin
    logic [23:0] rp;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    chk("reset_state", 14'h0000);

    // fill every palette entry so the model and RAM start identical
    for (int a = 0; a < 1024; a++) begin
      wr(10'(a), 3'b001, 4'($urandom));
      wr(10'(a), 3'b010, 4'($urandom));
      wr(10'(a), 3'b100, 4'($urandom));
    end
    wr(10'h023, 3'b001, 4'hF); wr(10'h023, 3'b110, 4'h0);
    wr(10'h145, 3'b010, 4'hF); wr(10'h145, 3'b101, 4'h0);
    wr(10'h270, 3'b001, 4'h1); wr(10'h270, 3'b010, 4'h2); wr(10'h270, 3'b100, 4'h3);
    wr(10'h200, 3'b001, 4'h4); wr(10'h200, 3'b010, 4'h5); wr(10'h200, 3'b100, 4'h6);
    wr_done();

    // transparency and order, with exact latency
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    step(8'h20, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    step(8'h20, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("order_red", RED);
    step(8'h20, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("order_green", GREEN);

    // prio_swap, toggled mid-stream
    repeat (3) step(8'h23, 8'h45, 8'h00, 3'b111, 1'b1, 1'b1, 1'b1);
    chk("swap_green", GREEN);
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("swap_hold1", GREEN);
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("swap_hold2", GREEN);
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("swap_change", RED);

    // fallback and enable mask
    repeat (3) step(8'h10, 8'h30, 8'h70, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("fallback_270", {4'h1, 4'h2, 4'h3, 2'b11});
    repeat (3) step(8'h10, 8'h30, 8'h70, 3'b011, 1'b0, 1'b1, 1'b1);
    chk("fallback_200", {4'h4, 4'h5, 4'h6, 2'b11});
    repeat (3) step(8'h23, 8'h45, 8'h00, 3'b110, 1'b0, 1'b1, 1'b1);
    chk("en0_off", GREEN);

    // blanking
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b0, 1'b1);
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("hblank_pre", RED);
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0);
    chk("hblank", {12'h000, 2'b01});
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("hblank_post", RED);
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("vblank", {12'h000, 2'b10});
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("vblank_post", RED);

    // palette load on consecutive clocks with pxl_cen low
    wr(10'h099, 3'b001, 4'hA); wr(10'h099, 3'b010, 4'hB); wr(10'h099, 3'b100, 4'hC);
    wr_done();
    repeat (3) step(8'h99, 8'h00, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("pal_load", {4'hA, 4'hB, 4'hC, 2'b11});

    // read-before-write on the same address
    step(8'h99, 8'h00, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    pend_en = 3'b001; pend_addr = 10'h099; pend_data = 4'h5;
    step(8'h99, 8'h00, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    step(8'h99, 8'h00, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("rbw_old", {4'hA, 4'hB, 4'hC, 2'b11});
    step(8'h99, 8'h00, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("rbw_new", {4'h5, 4'hB, 4'hC, 2'b11});

    // reset mid-frame, with a palette write committing during reset
    wr(10'h0AA, 3'b010, 4'h8); wr(10'h0AA, 3'b100, 4'h9);
    wr_done();
    repeat (3) step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("pre_rst", RED);
    @(negedge clk);
    rst = 1'b1; pxl_cen = 1'b1;
    prog_addr = 10'h0AA; prog_data = 4'h7; prog_en = 3'b001;
    @(negedge clk);
    rst = 1'b0; pxl_cen = 1'b0; prog_en = '0;
    chk("rst_clear", 14'h0000);
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("rst_c1", 14'h0000);
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("rst_c2", 14'h0000);
    step(8'h23, 8'h45, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("rst_c3", RED);
    repeat (3) step(8'hAA, 8'h00, 8'h00, 3'b111, 1'b0, 1'b1, 1'b1);
    chk("rst_write", {4'h7, 4'h8, 4'h9, 2'b11});

    // randomized traffic, checked by the model every cycle
    repeat (5000) begin
      @(negedge clk);
      rp = 24'($urandom);
      for (int l = 0; l < 3; l++)
        if ($urandom_range(0, 1) == 0) rp[l*8 +: 4] = 4'h0;
      lyr_pxl   = rp;
      layer_en  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      prio_swap = 1'($urandom);
      LHBL      = ($urandom_range(0, 7) != 0);
      LVBL      = ($urandom_range(0, 7) != 0);
      pxl_cen   = ($urandom_range(0, 2) == 0);
      prog_en   = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      prog_addr = ($urandom_range(0, 1) == 0) ? {2'($urandom), rp[7:0]} : 10'($urandom);
      prog_data = 4'($urandom);
      rst       = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0; pxl_cen = 1'b0; prog_en = '0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtkicker_mixer.md
# jtkicker_mixer

Parametrised N-layer colour mixer and palette stage for Konami-style video pipelines. It takes per-layer pixel indices from the tile and sprite engines and resolves priority and transparency. It looks the winning pixel up in a CPU/PROM-loaded RGB palette RAM and drives blanked RGB with matching delayed blanking signals. It generalises the fixed three-PROM colour mixer to any layer count and pixel width, and adds priority swap and a per-layer enable mask.

## Interface
Parameters:
- LAYERS, 3: number of layers, 2..4; layer 0 is the highest priority.
- PXLW, 8: pixel width per layer; [3:0] is the colour, [PXLW-1:4] is the palette; colour 0 is transparent.
- COLW, 4: bits per RGB channel, ≤ 4.
- PALAW = 2+PXLW (derived): palette RAM address width.

Ports:
- clk  in  1  system clock (48 MHz).
- rst  in  1  reset; one clock, synchronous, active-high.
- pxl_cen  in  1  pixel clock enable.
- lyr_pxl  in  LAYERS*PXLW  layer pixels; layer i at [i*PXLW +: PXLW].
- layer_en  in  LAYERS  per-layer enable; 0 forces that layer transparent.
- prio_swap  in  1  1 = layer 1 ranks above layer 0.
- LHBL, LVBL  in  1 each  active-low blanking, aligned with lyr_pxl.
- prog_addr  in  PALAW  palette write address.
- prog_data  in  4  palette nibble.
- prog_en  in  3  write strobes {B,G,R}; bit 0 writes R.
- red, green, blue  out  COLW each  pixel colour.
- LHBL_dly, LVBL_dly  out  1 each  blanking delayed to match RGB.

## Operation
- Stage 1, priority, on pxl_cen:
  - Effective order is 0,1,2,3; with prio_swap=1 it is 1,0,2,3. prio_swap is ignored if LAYERS<2.
  - Layer i is opaque when layer_en[i]=1 and lyr_pxl_i[3:0]≠0.
  - The winner is the first opaque layer in effective order. It registers pal_addr = {i[1:0], lyr_pxl_i}.
  - If no layer is opaque, the fallback is layer LAYERS-1: pal_addr = {LAYERS-1, lyr_pxl_(LAYERS-1)}. If layer_en[LAYERS-1]=0, pal_addr = {LAYERS-1, 0}.
  - LHBL and LVBL are registered alongside.
- Stage 2, palette read, on pxl_cen: synchronous read of the 3×4-bit entry at pal_addr; blanking advances.
- Stage 3, output, on pxl_cen:
  - RGB = entry[3 -: COLW] per channel when both delayed blanks are 1, else 0.
  - LHBL_dly and LVBL_dly are registered in the same stage.
- Palette writes:
  - On any clk with prog_en[c]=1, nibble c at prog_addr ← prog_data. Writes do not depend on pxl_cen.
  - Multiple prog_en bits may be set together.
  - A read of the address being written returns the old data (read-before-write).
- Changes to layer_en and prio_swap take effect at the next stage-1 sample. There is no glitch mid-pixel.

## Timing
- Latency is exactly 3 pxl_cen events from lyr_pxl/LHBL/LVBL sampling to RGB and *_dly. RGB and blanking stay aligned.
- Between pxl_cen pulses all pipeline registers hold.
- Reset (rst=1 on any clk):
  - Clears pal_addr, the stage-2 read register, red/green/blue and LHBL_dly/LVBL_dly to 0 on the next edge, so outputs are blanked.
  - Palette RAM contents are kept.
  - A palette write in the same cycle as rst still commits.
- After rst is released, the first valid output appears at the 3rd pxl_cen.
- Reset mid-line drops the in-flight pixels. No partial state survives.

## Test plan
- Transparency and order: LAYERS=3, palette entry {0,0x23} = RGB F/0/0 and {1,0x45} = 0/F/0. Drive layer0=0x23 and layer1=0x45, then layer0=0x20 and layer1=0x45. Expect red then green, each 3 pxl_cen later.
- prio_swap: same pixels, prio_swap=1. Expect green (layer 1 wins). Toggle prio_swap mid-stream; the change shows exactly 3 cen later.
- Fallback and enable:
  - All colours 0, layer2=0x70. Expect entry {2,0x70}.
  - Set layer_en=3'b011. Expect entry {2,0x00}.
  - layer_en[0]=0 with layer0=0x23. Expect layer 1 wins.
- Blanking: LHBL=0 for one pixel while the pixel is opaque. Expect RGB=0 and LHBL_dly=0 on the same cen, 3 cen later. LVBL behaves the same.
- Palette load: write R, G and B nibbles over consecutive clks with pxl_cen held low, then read back via a pixel. Expect the exact nibbles. A simultaneous write/read of the same address gives the old value first, then the new value.
- Reset mid-frame: assert rst for 1 clk while opaque pixels stream. Expect all outputs 0 next clk, palette preserved, and correct RGB at the 3rd cen after release.
